// File: rtl/botones_ctrl.sv
// Debounced front-panel buttons: press pulses for feed/medicine, a test-mode
// toggle, and a long-hold detector on B_Reset that emits a single pet-reset pulse.
module botones_ctrl #(
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int HOLD_CYCLES = 250_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic B_Test,
  input  logic B_Reset,
  input  logic B_Comida,
  input  logic B_Medicina,
  output logic modo_test,
  output logic reseteo,
  output logic Comida,
  output logic Medicina
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [27:0] HOLD_LAST = 28'(HOLD_CYCLES - 1);

  localparam int BTN_TEST  = 0;
  localparam int BTN_RESET = 1;
  localparam int BTN_FEED  = 2;
  localparam int BTN_MED   = 3;

  typedef enum logic [1:0] {
    IDLE,
    HOLDING,
    FIRED
  } state_t;

  logic [3:0] btn_n;
  logic [3:0] level;

  assign btn_n = {B_Medicina, B_Comida, B_Reset, B_Test};

  // One synchronizer + debouncer per button; level is the accepted "pressed" state.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             level_q, level_d;
      logic [DEB_W-1:0] cnt_q, cnt_d;

      always_comb begin
        sync1_d = ~btn_n[gi];
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DEB_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          level_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign level[gi] = level_q;
    end
  endgenerate

  logic [3:0] level_prev_q, level_prev_d;
  logic [3:0] press_q, press_d;
  state_t     state_q, state_d;
  logic [27:0] hold_q, hold_d;
  logic       reseteo_q, reseteo_d;
  logic       modo_q, modo_d;

  always_comb begin
    level_prev_d = level;
    press_d      = level & ~level_prev_q;

    state_d   = state_q;
    hold_d    = hold_q;
    reseteo_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_q[BTN_RESET]) begin
          state_d = HOLDING;
          hold_d  = '0;
        end
      end
      HOLDING: begin
        if (!level[BTN_RESET]) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_LAST) begin
          reseteo_d = 1'b1;
          state_d   = FIRED;
        end else if (hold_q != '1) begin
          hold_d = hold_q + 1'b1;
        end
      end
      FIRED: begin
        if (!level[BTN_RESET]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The pet reset overrides a test toggle landing on the same edge.
    modo_d = modo_q;
    if (reseteo_d) begin
      modo_d = 1'b0;
    end else if (press_q[BTN_TEST]) begin
      modo_d = ~modo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev_q <= '0;
      press_q      <= '0;
      state_q      <= IDLE;
      hold_q       <= '0;
      reseteo_q    <= 1'b0;
      modo_q       <= 1'b0;
    end else begin
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      reseteo_q    <= reseteo_d;
      modo_q       <= modo_d;
    end
  end

  assign modo_test = modo_q;
  assign reseteo   = reseteo_q;
  assign Comida    = press_q[BTN_FEED];
  assign Medicina  = press_q[BTN_MED];

endmodule

// File: tb/tb_botones_ctrl.sv
// Scoreboard bench for botones_ctrl with DEB_CYCLES=4, HOLD_CYCLES=10: stimulus
// queues expected pulse cycles, a negedge monitor pops and compares them.
module tb_botones_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic B_Test, B_Reset, B_Comida, B_Medicina;
  logic modo_test, reseteo, Comida, Medicina;

  botones_ctrl #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .B_Test    (B_Test),
    .B_Reset   (B_Reset),
    .B_Comida  (B_Comida),
    .B_Medicina(B_Medicina),
    .modo_test (modo_test),
    .reseteo   (reseteo),
    .Comida    (Comida),
    .Medicina  (Medicina)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
  } modo_ev_t;

  int       n_checks = 0;
  int       n_pass = 0;
  bit       mon_en = 1'b0;
  logic     modo_prev;
  int       q_com[$];
  int       q_med[$];
  int       q_rst[$];
  modo_ev_t q_modo[$];
  modo_ev_t ev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_modo(input int c, input int v);
    modo_ev_t e;
    e.cyc = c;
    e.val = v;
    q_modo.push_back(e);
  endtask

  // Press B_Test cleanly; toggle lands one edge after the press event.
  task automatic press_test(input int v);
    B_Test = 1'b0;
    push_modo(cyc + 8, v);
    tick(10);
    B_Test = 1'b1;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (Comida === 1'b1) begin
        $display("cycle %0d: Comida pulse", cyc);
        if (q_com.size() == 0) chk("comida_unexpected", cyc, -1);
        else chk("comida_cycle", cyc, q_com.pop_front());
      end
      if (Medicina === 1'b1) begin
        $display("cycle %0d: Medicina pulse", cyc);
        if (q_med.size() == 0) chk("medicina_unexpected", cyc, -1);
        else chk("medicina_cycle", cyc, q_med.pop_front());
      end
      if (reseteo === 1'b1) begin
        $display("cycle %0d: reseteo pulse", cyc);
        if (q_rst.size() == 0) chk("reseteo_unexpected", cyc, -1);
        else chk("reseteo_cycle", cyc, q_rst.pop_front());
      end
      if (modo_test !== modo_prev) begin
        $display("cycle %0d: modo_test -> %0b", cyc, modo_test);
        if (q_modo.size() == 0) begin
          chk("modo_unexpected", int'(modo_test), int'(modo_prev));
        end else begin
          ev = q_modo.pop_front();
          chk("modo_change_cycle", cyc, ev.cyc);
          chk("modo_value", int'(modo_test), ev.val);
        end
        modo_prev = modo_test;
      end
    end
  end

  initial begin
    reset      = 1'b1;
    B_Test     = 1'b1;
    B_Reset    = 1'b1;
    B_Comida   = 1'b1;
    B_Medicina = 1'b1;
    tick(3);
    chk("rst_modo_test", int'(modo_test), 0);
    chk("rst_reseteo", int'(reseteo), 0);
    chk("rst_comida", int'(Comida), 0);
    chk("rst_medicina", int'(Medicina), 0);
    modo_prev = modo_test;
    reset     = 1'b0;
    mon_en    = 1'b1;
    tick(2);

    // Single feed press; release gives no event
    B_Comida = 1'b0;
    q_com.push_back(cyc + 7);
    tick(12);
    B_Comida = 1'b1;
    tick(10);

    // Simultaneous feed + medicine
    B_Comida   = 1'b0;
    B_Medicina = 1'b0;
    q_com.push_back(cyc + 7);
    q_med.push_back(cyc + 7);
    tick(12);
    B_Comida   = 1'b1;
    B_Medicina = 1'b1;
    tick(10);

    // 3-cycle glitch on B_Test is filtered, then two clean presses
    B_Test = 1'b0;
    tick(3);
    B_Test = 1'b1;
    tick(10);
    press_test(1);
    press_test(0);

    // Long hold fires once and clears test mode; feed works meanwhile
    press_test(1);
    B_Reset = 1'b0;
    q_rst.push_back(cyc + 18);
    push_modo(cyc + 18, 0);
    tick(10);
    B_Comida = 1'b0;
    q_com.push_back(cyc + 7);
    tick(12);
    B_Comida = 1'b1;
    tick(18);
    B_Reset = 1'b1;
    tick(12);

    // Early release aborts the hold
    B_Reset = 1'b0;
    tick(9);
    B_Reset = 1'b1;
    tick(20);

    // Test event landing on the reseteo edge is discarded
    B_Reset = 1'b0;
    q_rst.push_back(cyc + 18);
    tick(10);
    B_Test = 1'b0;
    tick(8);
    chk("modo_on_fire_edge", int'(modo_test), 0);
    chk("reseteo_on_fire_edge", int'(reseteo), 1);
    tick(10);
    B_Test = 1'b1;
    tick(10);
    B_Reset = 1'b1;
    tick(12);

    // Block reset mid-hold with buttons held through deassertion
    press_test(1);
    B_Reset  = 1'b0;
    B_Comida = 1'b0;
    q_com.push_back(cyc + 7);
    push_modo(cyc + 13, 0);
    tick(12);
    reset = 1'b1;
    tick(2);
    chk("midrst_modo_test", int'(modo_test), 0);
    chk("midrst_reseteo", int'(reseteo), 0);
    chk("midrst_comida", int'(Comida), 0);
    chk("midrst_medicina", int'(Medicina), 0);
    tick(1);
    reset = 1'b0;
    q_com.push_back(cyc + 7);
    q_rst.push_back(cyc + 18);
    tick(40);
    B_Reset  = 1'b1;
    B_Comida = 1'b1;
    tick(15);

    chk("comida_pending", q_com.size(), 0);
    chk("medicina_pending", q_med.size(), 0);
    chk("reseteo_pending", q_rst.size(), 0);
    chk("modo_pending", q_modo.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
